// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared AXI4-Lite response codes and command-master FSM states
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        WRITE_ADDR_DATA = 3'd1,
        WRITE_RESP      = 3'd2,
        READ_ADDR       = 3'd3,
        READ_DATA       = 3'd4,
        RESPOND         = 3'd5
    } cmd_master_state_e;

endpackage

// File: rtl/axi4_lite_if.sv
// rtl/axi4_lite_if.sv - AXI4-Lite bus bundle with master and slave views
interface axi4_lite_if #(
    parameter int ALEN = 32,
    parameter int DLEN = 32
) (
    input logic aclk,
    input logic aresetn
);
    logic [ALEN-1:0]   awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DLEN-1:0]   wdata;
    logic [DLEN/8-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ALEN-1:0]   araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DLEN-1:0]   rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport M (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport S (
        input  aclk, aresetn,
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_watchdog.sv
// rtl/axi4_lite_watchdog.sv - enable/clear cycle counter that flags expiry on its LIMIT-th enabled cycle
module axi4_lite_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && !o_expire) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_en && (r_count == CW'(LIMIT - 1));
endmodule

// File: rtl/axi4_lite_cmd_master.sv
// rtl/axi4_lite_cmd_master.sv - single-outstanding AXI4-Lite initiator fed by a cmd/rsp stream
// Optional response watchdog enabled by AXIL_CMD_MASTER_TIMEOUT_EN.
module axi4_lite_cmd_master
    import axi4_lite_pkg::*;
#(
    parameter int ALEN           = 32,
    parameter int DLEN           = 32,
    parameter int SLEN           = DLEN / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [ALEN-1:0] cmd_addr,
    input  logic [DLEN-1:0] cmd_wdata,
    input  logic [SLEN-1:0] cmd_wstrb,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_write,
    output logic [DLEN-1:0] rsp_rdata,
    output logic [1:0]      rsp_resp,
    output logic            timeout_err,
    axi4_lite_if.M          m_axi
);
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    localparam logic IDLE_ABSORB = 1'b1;
`else
    localparam logic IDLE_ABSORB = 1'b0;
`endif

    cmd_master_state_e r_state, w_state_nxt;
    logic              r_cmd_ready, r_write;
    logic [ALEN-1:0]   r_addr;
    logic [DLEN-1:0]   r_wdata;
    logic [SLEN-1:0]   r_wstrb;
    logic              r_awvalid, r_wvalid, r_aw_done, r_w_done, r_bready, r_arvalid, r_rready;
    logic              r_rsp_valid, r_rsp_write;
    logic [DLEN-1:0]   r_rsp_rdata;
    axi_resp_e         r_rsp_resp;
    logic              w_cmd_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic              w_expired, w_timeout;

    assign w_cmd_hs = r_cmd_ready && cmd_valid;
    assign w_aw_hs  = r_awvalid && m_axi.awready;
    assign w_w_hs   = r_wvalid && m_axi.wready;
    assign w_b_hs   = r_bready && m_axi.bvalid;
    assign w_ar_hs  = r_arvalid && m_axi.arready;
    assign w_r_hs   = r_rready && m_axi.rvalid;

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: if (w_cmd_hs) w_state_nxt = cmd_write ? WRITE_ADDR_DATA : READ_ADDR;
            WRITE_ADDR_DATA:
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = WRITE_RESP;
            WRITE_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt = RESPOND;
                end else if (w_expired) begin
                    w_state_nxt = RESPOND;
                    w_timeout   = 1'b1;
                end
            end
            READ_ADDR: if (w_ar_hs) w_state_nxt = READ_DATA;
            READ_DATA: begin
                if (w_r_hs) begin
                    w_state_nxt = RESPOND;
                end else if (w_expired) begin
                    w_state_nxt = RESPOND;
                    w_timeout   = 1'b1;
                end
            end
            RESPOND: if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= OKAY;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == IDLE);
            r_bready    <= (w_state_nxt == WRITE_RESP) || (IDLE_ABSORB && w_state_nxt == IDLE);
            r_rready    <= (w_state_nxt == READ_DATA) || (IDLE_ABSORB && w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESPOND);

            if (w_cmd_hs) begin
                r_write   <= cmd_write;
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_awvalid <= cmd_write;
                r_wvalid  <= cmd_write;
                r_arvalid <= !cmd_write;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                // AW and W retire independently so either may be accepted first
                if (w_aw_hs) begin
                    r_awvalid <= 1'b0;
                    r_aw_done <= 1'b1;
                end
                if (w_w_hs) begin
                    r_wvalid <= 1'b0;
                    r_w_done <= 1'b1;
                end
                if (w_ar_hs) r_arvalid <= 1'b0;
            end

            if (r_state == WRITE_RESP && w_b_hs) begin
                r_rsp_write <= 1'b1;
                r_rsp_rdata <= '0;
                r_rsp_resp  <= axi_resp_e'(m_axi.bresp);
            end else if (r_state == READ_DATA && w_r_hs) begin
                r_rsp_write <= 1'b0;
                r_rsp_rdata <= m_axi.rdata;
                r_rsp_resp  <= axi_resp_e'(m_axi.rresp);
            end else if (w_timeout) begin
                r_rsp_write <= r_write;
                r_rsp_rdata <= '0;
                r_rsp_resp  <= DECERR;
            end
        end
    end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    logic w_wd_en, w_wd_clr, r_timeout_err;

    assign w_wd_en  = (r_state == WRITE_RESP) || (r_state == READ_DATA);
    assign w_wd_clr = (w_state_nxt != r_state);

    axi4_lite_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .i_clk    (aclk),
        .i_rst    (areset),
        .i_en     (w_wd_en),
        .i_clr    (w_wd_clr),
        .o_expire (w_expired)
    );

    always_ff @(posedge aclk) begin
        if (areset)         r_timeout_err <= 1'b0;
        else if (w_timeout) r_timeout_err <= 1'b1;
    end
    assign timeout_err = r_timeout_err;
`else
    assign w_expired   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_write     = r_rsp_write;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;

    assign m_axi.awaddr  = r_addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_wstrb;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.bready  = r_bready;
    assign m_axi.araddr  = r_addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.rready  = r_rready;
endmodule

// File: tb/tb_axi4_lite_cmd_master.sv
// tb/tb_axi4_lite_cmd_master.sv - directed bench for axi4_lite_cmd_master with a behavioural AXI4-Lite slave
module tb_axi4_lite_cmd_master;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    localparam int   TMO      = 16;
    localparam logic IDLE_RDY = 1'b1;
`else
    localparam int   TMO      = 1024;
    localparam logic IDLE_RDY = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        areset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        timeout_err;

    int n_vec  = 0;
    int n_fail = 0;

    axi4_lite_if #(.ALEN(32), .DLEN(32)) axi (.aclk(aclk), .aresetn(~areset));

    axi4_lite_cmd_master #(
        .ALEN(32), .DLEN(32), .SLEN(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .timeout_err (timeout_err),
        .m_axi       (axi)
    );

    always #5 aclk = ~aclk;

    // Slave knobs written by the stimulus, state owned by the slave process
    logic [31:0] mem [0:15];
    int          aw_wait, w_wait, r_wait, b_count;
    logic        b_block;
    logic [1:0]  r_resp_cfg;
    logic        got_aw, got_w, got_ar, p_aw, p_w, p_b, p_ar, p_r;
    logic [31:0] s_awaddr, s_araddr, s_wdata;
    logic [3:0]  s_wstrb;

    // Slave acts 1 time unit after each rising edge; p_* remember handshakes
    // that will complete on the following edge.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid  = 1'b0; axi.bresp  = 2'b00;
        axi.rvalid  = 1'b0; axi.rresp  = 2'b00; axi.rdata = '0;
        got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0; b_count = 0;
        p_aw = 1'b0; p_w = 1'b0; p_b = 1'b0; p_ar = 1'b0; p_r = 1'b0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        forever begin
            @(posedge aclk);
            #1;
            if (areset) begin
                got_aw = 1'b0; got_w = 1'b0; got_ar = 1'b0;
                axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
                axi.bvalid  = 1'b0; axi.rvalid = 1'b0;
            end else begin
                if (p_aw) got_aw = 1'b1;
                if (p_w)  got_w  = 1'b1;
                if (p_ar) got_ar = 1'b1;
                if (p_b) begin
                    axi.bvalid = 1'b0;
                    b_count++;
                end
                if (p_r) axi.rvalid = 1'b0;
                if (got_aw && got_w && !axi.bvalid && !b_block) begin
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                    axi.bvalid = 1'b1;
                    axi.bresp  = 2'b00;
                    got_aw = 1'b0;
                    got_w  = 1'b0;
                end
                if (got_ar && !axi.rvalid) begin
                    if (r_wait > 0) begin
                        r_wait--;
                    end else begin
                        axi.rvalid = 1'b1;
                        axi.rdata  = mem[s_araddr[5:2]];
                        axi.rresp  = r_resp_cfg;
                        got_ar = 1'b0;
                    end
                end
                axi.awready = axi.awvalid && !got_aw && (aw_wait == 0);
                if (axi.awvalid && aw_wait > 0) aw_wait--;
                axi.wready  = axi.wvalid && !got_w && (w_wait == 0);
                if (axi.wvalid && w_wait > 0) w_wait--;
                axi.arready = axi.arvalid;
            end
            p_aw = axi.awvalid && axi.awready;
            p_w  = axi.wvalid  && axi.wready;
            p_ar = axi.arvalid && axi.arready;
            p_b  = axi.bvalid  && axi.bready;
            p_r  = axi.rvalid  && axi.rready;
            if (p_aw) s_awaddr = axi.awaddr;
            if (p_w) begin
                s_wdata = axi.wdata;
                s_wstrb = axi.wstrb;
            end
            if (p_ar) s_araddr = axi.araddr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge of the handshake cycle; returns one cycle later.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        chk("cmd_ready_at_issue", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    int b0;

    initial begin
        areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        aw_wait = 0; w_wait = 0; r_wait = 0; b_block = 1'b0; r_resp_cfg = 2'b00;

        repeat (3) @(negedge aclk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_timeout_err", timeout_err, 0);
        areset = 1'b0;
        @(negedge aclk);
        chk("cmd_ready_after_rst", cmd_ready, 1);

        // Zero-wait write
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("wr_awvalid_n1", axi.awvalid, 1);
        chk("wr_wvalid_n1", axi.wvalid, 1);
        chk("wr_awaddr", axi.awaddr, 32'h10);
        chk("wr_wdata", axi.wdata, 32'hDEADBEEF);
        chk("wr_wstrb", axi.wstrb, 4'hF);
        chk("wr_awprot", axi.awprot, 0);
        chk("wr_cmd_ready_busy", cmd_ready, 0);
        @(negedge aclk);
        chk("wr_awvalid_n2", axi.awvalid, 0);
        chk("wr_wvalid_n2", axi.wvalid, 0);
        chk("wr_bready_n2", axi.bready, 1);
        chk("wr_rsp_valid_n2", rsp_valid, 0);
        @(negedge aclk);
        chk("wr_rsp_valid_n3", rsp_valid, 1);
        chk("wr_rsp_write", rsp_write, 1);
        chk("wr_rsp_resp", rsp_resp, 2'b00);
        chk("wr_rsp_rdata", rsp_rdata, 0);
        @(negedge aclk);
        chk("wr_rsp_valid_n4", rsp_valid, 0);
        chk("idle_bready", axi.bready, IDLE_RDY);
        chk("idle_rready", axi.rready, IDLE_RDY);

        // Read back, issued back-to-back
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        chk("rd_arvalid_n1", axi.arvalid, 1);
        chk("rd_araddr", axi.araddr, 32'h10);
        chk("rd_arprot", axi.arprot, 0);
        @(negedge aclk);
        chk("rd_arvalid_n2", axi.arvalid, 0);
        chk("rd_rready_n2", axi.rready, 1);
        @(negedge aclk);
        chk("rd_rsp_valid_n3", rsp_valid, 1);
        chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("rd_rsp_resp", rsp_resp, 2'b00);
        chk("rd_rsp_write", rsp_write, 0);
        @(negedge aclk);

        // W accepted three cycles before AW, partial strobes
        aw_wait = 3;
        b0 = b_count;
        issue(1'b1, 32'h14, 32'h12345678, 4'h3);
        chk("skew_awvalid_n1", axi.awvalid, 1);
        chk("skew_wvalid_n1", axi.wvalid, 1);
        @(negedge aclk);
        chk("skew_wvalid_n2", axi.wvalid, 0);
        chk("skew_awvalid_n2", axi.awvalid, 1);
        repeat (2) @(negedge aclk);
        chk("skew_awvalid_n4", axi.awvalid, 1);
        chk("skew_bready_n4", axi.bready, 0);
        @(negedge aclk);
        chk("skew_awvalid_n5", axi.awvalid, 0);
        chk("skew_bready_n5", axi.bready, 1);
        @(negedge aclk);
        chk("skew_rsp_valid", rsp_valid, 1);
        chk("skew_rsp_resp", rsp_resp, 2'b00);
        chk("skew_rsp_write", rsp_write, 1);
        @(negedge aclk);
        chk("skew_one_b", b_count, b0 + 1);

        // SLVERR read with the response consumer stalled for five cycles
        r_resp_cfg = 2'b10;
        rsp_ready  = 1'b0;
        issue(1'b0, 32'h14, 32'h0, 4'h0);
        repeat (2) @(negedge aclk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_rdata", rsp_rdata, 32'h00005678);
            chk("stall_rsp_resp", rsp_resp, 2'b10);
            chk("stall_rsp_write", rsp_write, 0);
            chk("stall_cmd_ready", cmd_ready, 0);
            @(negedge aclk);
        end
        chk("stall_rsp_valid_end", rsp_valid, 1);
        rsp_ready  = 1'b1;
        r_resp_cfg = 2'b00;
        @(negedge aclk);
        chk("stall_released", rsp_valid, 0);

        // Reset while waiting in READ_DATA
        r_wait = 20;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        chk("rst_mid_arvalid", axi.arvalid, 1);
        @(negedge aclk);
        chk("rst_mid_rready", axi.rready, 1);
        areset = 1'b1;
        @(negedge aclk);
        chk("rst_mid_arvalid_0", axi.arvalid, 0);
        chk("rst_mid_rready_0", axi.rready, 0);
        chk("rst_mid_awvalid_0", axi.awvalid, 0);
        chk("rst_mid_wvalid_0", axi.wvalid, 0);
        chk("rst_mid_rsp_valid_0", rsp_valid, 0);
        chk("rst_mid_cmd_ready_0", cmd_ready, 0);
        areset = 1'b0;
        r_wait = 0;
        @(negedge aclk);
        chk("rst_mid_cmd_ready_1", cmd_ready, 1);
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        repeat (2) @(negedge aclk);
        chk("post_rst_rsp_valid", rsp_valid, 1);
        chk("post_rst_rdata", rsp_rdata, 32'hDEADBEEF);
        @(negedge aclk);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        // Slave never answers B: watchdog closes the transaction with DECERR
        b_block = 1'b1;
        issue(1'b1, 32'h18, 32'hCAFEF00D, 4'hF);
        @(negedge aclk);
        chk("tmo_bready", axi.bready, 1);
        repeat (15) @(negedge aclk);
        chk("tmo_rsp_valid_early", rsp_valid, 0);
        chk("tmo_err_early", timeout_err, 0);
        @(negedge aclk);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_resp", rsp_resp, 2'b11);
        chk("tmo_rsp_rdata", rsp_rdata, 0);
        chk("tmo_rsp_write", rsp_write, 1);
        chk("tmo_err_set", timeout_err, 1);
        @(negedge aclk);
        chk("tmo_idle_bready", axi.bready, 1);
        chk("tmo_cmd_ready", cmd_ready, 1);
        b0 = b_count;
        b_block = 1'b0;
        repeat (3) @(negedge aclk);
        chk("tmo_late_b_absorbed", b_count, b0 + 1);
        chk("tmo_err_sticky", timeout_err, 1);
        chk("tmo_no_spurious_rsp", rsp_valid, 0);
`else
        chk("timeout_err_tied", timeout_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/axi4_lite_cmd_master.md
# axi4_lite_cmd_master

- Single-outstanding AXI4-Lite initiator that turns a simple valid/ready command stream into AXI4-Lite read and write transactions.
- Returns each transaction's data and response code on a valid/ready response stream.
- Drives the master end of an `axi4_lite_if`; sits between on-board control logic (button/UART command decoders, test sequencers) and the GPIO register slaves.

## Interface
- `ALEN`, 32, address width
- `DLEN`, 32, data width
- `SLEN`, `DLEN/8`, write-strobe width
- `TIMEOUT_CYCLES`, 1024, response watchdog limit; used only with the macro
- `aclk` in 1: clock
- `areset` in 1: reset; synchronous, active-high
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: command accepted when high with `cmd_valid`
- `cmd_write` in 1: 1 = write, 0 = read
- `cmd_addr` in ALEN: byte address
- `cmd_wdata` in DLEN: write data
- `cmd_wstrb` in SLEN: write strobes
- `rsp_valid` out 1: response available
- `rsp_ready` in 1: response consumed
- `rsp_write` out 1: echo of `cmd_write`
- `rsp_rdata` out DLEN: read data; 0 for writes
- `rsp_resp` out 2: AXI response code
- `timeout_err` out 1: sticky watchdog flag; constant 0 without the macro
- `m_axi` `axi4_lite_if.M`: AXI4-Lite master port
  - The interface's own `aclk`/`aresetn` are not used by this block.

## Operation
- FSM states: IDLE, WRITE_ADDR_DATA, WRITE_RESP, READ_ADDR, READ_DATA, RESPOND.
- IDLE
  - `cmd_ready`=1.
  - On handshake, latch all `cmd_*` fields.
  - Go to WRITE_ADDR_DATA if `cmd_write`, otherwise READ_ADDR.
- WRITE_ADDR_DATA
  - Assert `awvalid` and `wvalid` together.
  - Each valid drops independently after its own handshake; track this with flags `aw_done` and `w_done`.
  - Go to WRITE_RESP once both handshakes have completed, including when both complete in the same cycle.
  - AW and W accept in either order.
- WRITE_RESP
  - `bready`=1.
  - On `bvalid`, capture `bresp`, set `rsp_rdata`=0 and go to RESPOND.
- READ_ADDR
  - `arvalid`=1 until `arready`, then go to READ_DATA.
- READ_DATA
  - `rready`=1.
  - On `rvalid`, capture `rdata` and `rresp`, then go to RESPOND.
- RESPOND
  - `rsp_valid`=1; all `rsp_*` fields are held stable until `rsp_ready`, then go to IDLE.
- `awprot`/`arprot` = 3'b000 always.
- `awaddr`/`araddr`/`wdata`/`wstrb` come from the latched command and are stable while their valid is high.
- Once asserted, a valid is never withdrawn before its handshake.
- Reset mid-transaction: the FSM returns to IDLE and all valids drop immediately. The slave must be reset by the same event.

## Timing
- Reset values:
  - all outputs 0;
  - `cmd_ready` rises on the first cycle after `areset` falls.
- All AXI and `rsp_*` outputs are registered.
- No command is accepted while `rsp_valid`=1. `cmd_ready` is low outside IDLE.
- Minimum write latency (zero-wait slave):
  - `cmd` handshake at cycle N;
  - `awvalid`/`wvalid` high at N+1;
  - `bready` high at N+2 (`bvalid` at N+2);
  - `rsp_valid` at N+3.
- Minimum read latency:
  - `arvalid` at N+1;
  - `rready` at N+2;
  - `rsp_valid` at N+3.
- Back-to-back throughput: one transaction per 4 cycles when `rsp_ready` is held at 1.

## Configuration
- `AXIL_CMD_MASTER_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in WRITE_RESP or READ_DATA. It clears on every state entry.
  - When the count reaches `TIMEOUT_CYCLES`, go to RESPOND with `rsp_resp`=2'b11 and `rsp_rdata`=0, and set `timeout_err` (cleared only by reset).
  - In IDLE, `bready` and `rready` are held at 1, so late B/R beats are absorbed and discarded.
- Macro undefined:
  - No counter.
  - The block waits indefinitely in the response states.
  - `bready`/`rready` are 0 in IDLE.
  - `timeout_err` is tied to 0.

## Structure
- Package `axi4_lite_pkg`:
  - `axi_resp_e` (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11);
  - `cmd_master_state_e` FSM enum.
- Sub-module `axi4_lite_watchdog` (enable/clear/expire counter), instantiated only under the macro.
- Everything else lives in a single module.

## Test plan
- Write `addr`=0x10, `wdata`=0xDEADBEEF, `wstrb`=4'hF to a zero-wait slave -> AW/W at N+1, `rsp_valid` at N+3 with `rsp_resp`=00 and `rsp_write`=1.
- Read 0x10 after that write -> `rsp_rdata`=0xDEADBEEF, `rsp_resp`=00, latency 3 cycles.
- Slave asserts `wready` 3 cycles before `awready` -> `wvalid` drops after its handshake, `awvalid` holds, exactly one B is accepted, and the response is correct.
- Slave returns `rresp`=2'b10 with `rsp_ready` held low 5 cycles -> `rsp_*` stable for 5 cycles and `cmd_ready`=0 throughout.
- `areset` pulsed in READ_DATA -> next cycle all valids are 0; `cmd_ready`=1 the cycle after reset release.
- With the macro and `TIMEOUT_CYCLES`=16, the slave never asserts `bvalid` -> `rsp_resp`=2'b11 after 16 cycles; `timeout_err`=1 and sticky.
